// File: rtl/async_fifo_top.sv
// Same-clock FIFO with registered full/empty flags and registered read data.
// Define FIFO_COUNT_EN to add a registered occupancy output (count).
module async_fifo_top #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  winc,
  output logic                  wfull,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rempty
`ifdef FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   count
`endif
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [PTR_W-1:0]      wptr_nxt;
  logic [PTR_W-1:0]      rptr_nxt;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  full_nxt;
  logic                  empty_nxt;

  // Accepts are qualified by the registered flags, so inputs never reach outputs combinationally.
  always_comb begin
    wr_acc    = winc && !wfull;
    rd_acc    = rinc && !rempty;
    wptr_nxt  = wptr + PTR_W'(wr_acc);
    rptr_nxt  = rptr + PTR_W'(rd_acc);
    empty_nxt = (wptr_nxt == rptr_nxt);
    full_nxt  = (wptr_nxt[ADDR_WIDTH] != rptr_nxt[ADDR_WIDTH]) &&
                (wptr_nxt[ADDR_WIDTH-1:0] == rptr_nxt[ADDR_WIDTH-1:0]);
  end

  // Storage has no reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr[ADDR_WIDTH-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      rdata  <= '0;
      wfull  <= 1'b0;
      rempty <= 1'b1;
    end else begin
      wptr   <= wptr_nxt;
      rptr   <= rptr_nxt;
      wfull  <= full_nxt;
      rempty <= empty_nxt;
      if (rd_acc) begin
        rdata <= mem[rptr[ADDR_WIDTH-1:0]];
      end
    end
  end

`ifdef FIFO_COUNT_EN
  // Occupancy tracks the pointer difference, wrapping with the extended pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= wptr_nxt - rptr_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_async_fifo_top.sv
// Directed bench for async_fifo_top: reset, fill, overflow, drain, underflow,
// simultaneous access and asynchronous mid-operation reset.
module tb_async_fifo_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wdata = '0;
  logic       winc = 1'b0;
  logic       rinc = 1'b0;
  logic       wfull;
  logic       rempty;
  logic [7:0] rdata;
`ifdef FIFO_COUNT_EN
  logic [10:0] count;
`endif

  int vectors = 0;
  int miscompares = 0;

  async_fifo_top #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) dut (
    .clk    (clk),
    .rst    (rst),
    .wdata  (wdata),
    .winc   (winc),
    .wfull  (wfull),
    .rinc   (rinc),
    .rdata  (rdata),
    .rempty (rempty)
`ifdef FIFO_COUNT_EN
    ,
    .count  (count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One edge with the given strobes; returns at the following falling edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    winc  = w;
    rinc  = r;
    wdata = d;
    @(negedge clk);
    winc = 1'b0;
    rinc = 1'b0;
  endtask

  initial begin
    // Reset held for two cycles
    @(negedge clk);
    @(negedge clk);
    check("reset_rempty", 32'(rempty), 32'd1);
    check("reset_wfull", 32'(wfull), 32'd0);
    check("reset_rdata", 32'(rdata), 32'h00);
`ifdef FIFO_COUNT_EN
    check("reset_count", 32'(count), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Fill
    for (int i = 0; i < 1024; i++) begin
      step(1'b1, 1'b0, 8'(i));
      if (i == 0)    check("fill_first_rempty", 32'(rempty), 32'd0);
      if (i == 1022) check("fill_1023_wfull", 32'(wfull), 32'd0);
      if (i == 1023) check("fill_1024_wfull", 32'(wfull), 32'd1);
    end
`ifdef FIFO_COUNT_EN
    check("full_count", 32'(count), 32'd1024);
`endif

    // Overflow write is dropped
    step(1'b1, 1'b0, 8'(500));
    check("overflow_wfull", 32'(wfull), 32'd1);

    // Drain
    for (int j = 0; j < 1024; j++) begin
      step(1'b0, 1'b1, 8'h00);
      check("drain_rdata", 32'(rdata), 32'(j[7:0]));
      if (j == 0)    check("drain_first_wfull", 32'(wfull), 32'd0);
      if (j == 1022) check("drain_1023_rempty", 32'(rempty), 32'd0);
      if (j == 1023) check("drain_last_rempty", 32'(rempty), 32'd1);
    end

    // Underflow read is ignored
    step(1'b0, 1'b1, 8'h00);
    check("underflow_rempty", 32'(rempty), 32'd1);
    check("underflow_rdata", 32'(rdata), 32'hFF);

    // Simultaneous while empty: write wins
    step(1'b1, 1'b1, 8'h5C);
    check("simul_empty_rempty", 32'(rempty), 32'd0);
    check("simul_empty_rdata", 32'(rdata), 32'hFF);

    // Simultaneous with one word: both accepted
    step(1'b1, 1'b1, 8'h77);
    check("simul_mid_rdata", 32'(rdata), 32'h5C);
    check("simul_mid_rempty", 32'(rempty), 32'd0);
    step(1'b0, 1'b1, 8'h00);
    check("simul_mid_pop", 32'(rdata), 32'h77);
    check("simul_mid_empty", 32'(rempty), 32'd1);

    // Refill and access simultaneously while full: read wins
    for (int i = 0; i < 1024; i++) begin
      step(1'b1, 1'b0, 8'(i + 3));
    end
    check("refill_wfull", 32'(wfull), 32'd1);
    step(1'b1, 1'b1, 8'hEE);
    check("simul_full_rdata", 32'(rdata), 32'h03);
    check("simul_full_wfull", 32'(wfull), 32'd0);
`ifdef FIFO_COUNT_EN
    check("simul_full_count", 32'(count), 32'd1023);
`endif
    step(1'b0, 1'b1, 8'h00);
    check("after_full_pop", 32'(rdata), 32'h04);

    // Clean restart, then five writes and an asynchronous reset between edges
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 8'h10 + 8'(i));
    end
    check("pre_reset_rempty", 32'(rempty), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rempty", 32'(rempty), 32'd1);
    check("async_rst_wfull", 32'(wfull), 32'd0);
    check("async_rst_rdata", 32'(rdata), 32'h00);
`ifdef FIFO_COUNT_EN
    check("async_rst_count", 32'(count), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b0, 8'hA1);
    step(1'b1, 1'b0, 8'hA2);
    step(1'b1, 1'b0, 8'hA3);
    step(1'b0, 1'b1, 8'h00);
    check("post_rst_rd0", 32'(rdata), 32'hA1);
    step(1'b0, 1'b1, 8'h00);
    check("post_rst_rd1", 32'(rdata), 32'hA2);
    step(1'b0, 1'b1, 8'h00);
    check("post_rst_rd2", 32'(rdata), 32'hA3);
    check("post_rst_empty", 32'(rempty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/async_fifo_top.md
Name: async_fifo_top

Overview:
- Single-clock, first-in/first-out buffer with independent write and read request strobes, a full flag and an empty flag.
- Default configuration: 1024 words of 8 bits.
- Sits between a producer and a consumer in the same clock domain and absorbs rate mismatch between them.
- Storage is an internal register array. Occupancy is tracked with extended-width (ADDR_WIDTH+1) binary pointers.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 10, address bits; depth = 2**ADDR_WIDTH words (1024).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous assert, active-high; synchronous deassert is the integrator's responsibility.
- wdata  input  DATA_WIDTH  write data, sampled when a write is accepted.
- winc  input  1  write request, one word per clk edge while high.
- wfull  output  1  FIFO holds 2**ADDR_WIDTH words.
- rinc  input  1  read request, one word per clk edge while high.
- rdata  output  DATA_WIDTH  registered read data: last word popped.
- rempty  output  1  FIFO holds 0 words.

Behaviour:
- Reset (rst=1, asynchronous):
  - wptr=0, rptr=0, rdata=0, wfull=0, rempty=1.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored words immediately.
- Pointers:
  - wptr and rptr are ADDR_WIDTH+1 bits wide.
  - The low ADDR_WIDTH bits address memory.
  - The MSB toggles on each wrap; pointers wrap naturally modulo 2**(ADDR_WIDTH+1).
- Write accept = winc && !wfull, evaluated before the edge. On accept: mem[wptr[ADDR_WIDTH-1:0]] <= wdata; wptr <= wptr+1.
- Read accept = rinc && !rempty, evaluated before the edge. On accept: rdata <= mem[rptr[ADDR_WIDTH-1:0]]; rptr <= rptr+1.
- Read latency: the popped word appears on rdata right after the accepting edge (1-cycle registered). rdata holds its value until the next accepted read.
- Flags: registered, updated on the same edge as the pointers, so they are valid in the cycle after any accept.
  - rempty = (next wptr == next rptr).
  - wfull = (next wptr[ADDR_WIDTH] != next rptr[ADDR_WIDTH]) && (next low bits equal).
- Write while full: ignored. No memory write, wptr unchanged, wfull stays 1.
- Read while empty: ignored. rptr and rdata unchanged, rempty stays 1.
- Simultaneous winc and rinc:
  - Not full and not empty: both accepted; occupancy and flags unchanged.
  - When full: the read is accepted and the write is dropped; wfull then goes to 0.
  - When empty: the write is accepted and the read is dropped; rempty then goes to 0.
- No combinational path from any input to any output.

Optional Feature:
- Macro: FIFO_COUNT_EN.
- Defined: adds output port count [ADDR_WIDTH:0] = wptr - rptr (modulo 2**(ADDR_WIDTH+1)).
  - Registered and updated with the pointers.
  - Reset value 0.
  - Range 0..2**ADDR_WIDTH.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst=1 for 2 cycles with winc/rinc low -> rempty=1, wfull=0, rdata=0. With FIFO_COUNT_EN, count=0.
- Fill: write i=0..1023 as single-cycle winc pulses, wdata=i[7:0] -> wfull=0 after 1023 writes, wfull=1 after the 1024th, rempty=0 after the first write.
- Overflow: write 500 while full -> rejected; wfull stays 1; the first subsequent read returns 0, not 500.
- Drain: 1024 single-cycle rinc pulses -> after pop j, rdata==j[7:0]; rempty=1 after the 1024th pop, and wfull=0 after the first pop.
- Underflow and simultaneous access:
  - Extra read when empty -> rempty stays 1, rdata stays 1023[7:0]=0xFF.
  - winc+rinc on the same edge while empty -> write accepted, read dropped, rempty=0 next cycle.
- Reset mid-operation: write 5 words, assert rst asynchronously between edges -> rempty=1 and wfull=0 immediately; after release, 3 writes (0xA1,0xA2,0xA3) read back in order.
